// File: rtl/reg_file.sv
// reg_file: 32x32 MIPS register file, R0 hardwired to zero; define REGFILE_BYPASS_EN for write-to-read forwarding
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [DATA_W-1:0] rd1_data
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic wr_ok;
  assign wr_ok = wr_en && (wr_num != '0);
  always_ff @(posedge clk) begin
    if (!reset)
      for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
    else if (wr_ok)
      regs[wr_num] <= wr_data;
  end
`ifdef REGFILE_BYPASS_EN
  logic fwd;
  assign fwd = reset && wr_ok;
  always_comb begin
    rd0_data = (rd0_num == '0) ? '0 : (fwd && rd0_num == wr_num) ? wr_data : regs[rd0_num];
    rd1_data = (rd1_num == '0) ? '0 : (fwd && rd1_num == wr_num) ? wr_data : regs[rd1_num];
  end
`else
  always_comb begin
    rd0_data = (rd0_num == '0) ? '0 : regs[rd0_num];
    rd1_data = (rd1_num == '0) ? '0 : regs[rd1_num];
  end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file
module tb_reg_file;
  logic clk = 0, reset = 0, wr_en = 0;
  logic [4:0] wr_num = 0, rd0_num = 0, rd1_num = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rd0_data, rd1_data;
  int checks = 0, failures = 0;
  typedef struct { string tag; logic port; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  reg_file dut (
    .clk(clk), .reset(reset), .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en),
    .rd0_num(rd0_num), .rd0_data(rd0_data), .rd1_num(rd1_num), .rd1_data(rd1_data)
  );

  always #5 clk = ~clk;

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.port ? rd1_data : rd0_data;
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s port%0d observed=%h expected=%h", e.tag, e.port, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] n0, input logic [4:0] n1,
                    input logic [31:0] e0, input logic [31:0] e1);
    rd0_num = n0;
    rd1_num = n1;
    sb.push_back('{tag, 1'b0, e0});
    sb.push_back('{tag, 1'b1, e1});
    drain();
  endtask

  task automatic wr(input logic [4:0] n, input logic [31:0] d, input logic en);
    @(negedge clk);
    wr_en = en;
    wr_num = n;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    rd("rst_init", 5'd5, 5'd31, 32'h0, 32'h0);
    reset = 1;
    wr(5'd5, 32'hDEADBEEF, 1'b1);
    rd("pre_rst", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    @(negedge clk);
    reset = 0;
    wr_en = 1;
    wr_num = 5'd7;
    wr_data = 32'h1234;
    @(posedge clk);
    #1;
    reset = 1;
    wr_en = 0;
    rd("rst_r5", 5'd5, 5'd7, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) rd("rst_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    wr(5'd29, 32'h80120000, 1'b1);
    wr(5'd31, 32'h00000000, 1'b1);
    wr(5'd3, 32'hA5A5A5A5, 1'b1);
    rd("basic", 5'd29, 5'd3, 32'h80120000, 32'hA5A5A5A5);
    rd("basic_r31", 5'd31, 5'd31, 32'h0, 32'h0);
    wr(5'd0, 32'hFFFFFFFF, 1'b1);
    rd("r0", 5'd0, 5'd0, 32'h0, 32'h0);
    wr(5'd9, 32'h11111111, 1'b1);
    wr(5'd9, 32'h22222222, 1'b0);
    rd("wr_en_gate", 5'd9, 5'd9, 32'h11111111, 32'h11111111);
    wr(5'd4, 32'd4, 1'b1);
    wr(5'd6, 32'd6, 1'b1);
    rd("dual", 5'd4, 5'd6, 32'd4, 32'd6);
    wr(5'd20, 32'h1, 1'b1);
    wr(5'd20, 32'h2, 1'b1);
    rd("b2b", 5'd20, 5'd20, 32'h2, 32'h2);
    wr(5'd12, 32'h0000000A, 1'b1);
    @(negedge clk);
    wr_en = 1;
    wr_num = 5'd12;
    wr_data = 32'h0000000B;
`ifdef REGFILE_BYPASS_EN
    rd("same_cyc", 5'd12, 5'd4, 32'h0000000B, 32'd4);
`else
    rd("same_cyc", 5'd12, 5'd4, 32'h0000000A, 32'd4);
`endif
    @(posedge clk);
    #1;
    wr_en = 0;
    rd("post_wr", 5'd12, 5'd12, 32'h0000000B, 32'h0000000B);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
